// File: rtl/fft_pkg.sv
// Shared constants, read-FSM encoding and slot-order helper for the FFT frame collector.
package fft_pkg;

  localparam int DW    = 32;
  localparam int N_PTS = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_PRESENT = 2'd1,
    R_WAIT    = 2'd2
  } rstate_t;

  function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_collect_if.sv
// Sample-in / frame-out bundle between the FFT core, the collector and the peak analyzer.
interface fft_collect_if;
  logic                   in_valid;
  logic                   in_ready;
  logic [fft_pkg::DW-1:0] in_data;
  logic                   drop;
  logic                   fft_valid;
  logic                   ana_done;
  logic [fft_pkg::DW-1:0] fft_d0,  fft_d1,  fft_d2,  fft_d3;
  logic [fft_pkg::DW-1:0] fft_d4,  fft_d5,  fft_d6,  fft_d7;
  logic [fft_pkg::DW-1:0] fft_d8,  fft_d9,  fft_d10, fft_d11;
  logic [fft_pkg::DW-1:0] fft_d12, fft_d13, fft_d14, fft_d15;

  modport master (
    output in_valid, in_data, ana_done,
    input  in_ready, drop, fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    input  fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15
  );

  modport slave (
    input  in_valid, in_data, ana_done,
    output in_ready, drop, fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15
  );
endinterface

// File: rtl/fft_bank16.sv
// One 16-entry frame bank: single write port, all entries visible in parallel.
module fft_bank16
  import fft_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [IDX_W-1:0]            waddr,
  input  logic [DW-1:0]               wdata,
  output logic [N_PTS-1:0][DW-1:0]    rd
);

  logic [N_PTS-1:0][DW-1:0] mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd = mem;

endmodule

// File: rtl/fft_collect.sv
// Double-buffered serial-to-parallel collector: fills one bank while the analyzer reads the other.
// state     | meaning
// R_IDLE    | no frame presented; pick the oldest full bank
// R_PRESENT | fft_valid pulse cycle for the chosen bank
// R_WAIT    | frame held on fft_d* until ana_done releases it
module fft_collect
  import fft_pkg::*;
#(
  parameter bit BIT_REV = 1'b1
) (
  input  logic clk,
  input  logic rst,
  fft_collect_if.slave bus
);

  logic [IDX_W-1:0]         wcnt;
  logic                     wbank;
  logic                     rbank;
  logic [1:0]               full;
  rstate_t                  rstate;
  logic                     fft_valid_q;
  logic                     accept;
  logic                     last;
  logic                     rel;
  logic                     other_free;
  logic [IDX_W-1:0]         waddr;
  logic [N_PTS-1:0][DW-1:0] rd0, rd1, rd_sel;

  assign accept     = bus.in_valid && !full[wbank];
  assign last       = accept && (wcnt == IDX_W'(N_PTS - 1));
  assign rel        = (rstate == R_WAIT) && bus.ana_done;
  // The other bank counts as free if it is released on this very edge.
  assign other_free = !full[~wbank] || (rel && (rbank == ~wbank));
  assign waddr      = BIT_REV ? bitrev4(wcnt) : wcnt;

  assign bus.in_ready  = !full[wbank];
  assign bus.drop      = bus.in_valid && full[wbank];
  assign bus.fft_valid = fft_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      wbank <= 1'b0;
      full  <= 2'b00;
    end else begin
      if (accept) wcnt <= wcnt + IDX_W'(1);
      if (rel)    full[rbank] <= 1'b0;
      if (last)   full[wbank] <= 1'b1;
      if (last ? other_free : (full[wbank] && rel && (rbank != wbank)))
        wbank <= ~wbank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate      <= R_IDLE;
      rbank       <= 1'b0;
      fft_valid_q <= 1'b0;
    end else begin
      fft_valid_q <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (full[~wbank]) begin
            rbank       <= ~wbank;
            rstate      <= R_PRESENT;
            fft_valid_q <= 1'b1;
          end else if (full[wbank]) begin
            rbank       <= wbank;
            rstate      <= R_PRESENT;
            fft_valid_q <= 1'b1;
          end
        end
        R_PRESENT: rstate <= R_WAIT;
        R_WAIT:    if (bus.ana_done) rstate <= R_IDLE;
        default:   rstate <= R_IDLE;
      endcase
    end
  end

  fft_bank16 u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && !wbank),
    .waddr (waddr),
    .wdata (bus.in_data),
    .rd    (rd0)
  );

  fft_bank16 u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && wbank),
    .waddr (waddr),
    .wdata (bus.in_data),
    .rd    (rd1)
  );

  assign rd_sel = rbank ? rd1 : rd0;

  assign bus.fft_d0  = rd_sel[0];
  assign bus.fft_d1  = rd_sel[1];
  assign bus.fft_d2  = rd_sel[2];
  assign bus.fft_d3  = rd_sel[3];
  assign bus.fft_d4  = rd_sel[4];
  assign bus.fft_d5  = rd_sel[5];
  assign bus.fft_d6  = rd_sel[6];
  assign bus.fft_d7  = rd_sel[7];
  assign bus.fft_d8  = rd_sel[8];
  assign bus.fft_d9  = rd_sel[9];
  assign bus.fft_d10 = rd_sel[10];
  assign bus.fft_d11 = rd_sel[11];
  assign bus.fft_d12 = rd_sel[12];
  assign bus.fft_d13 = rd_sel[13];
  assign bus.fft_d14 = rd_sel[14];
  assign bus.fft_d15 = rd_sel[15];

endmodule

// File: tb/tb_fft_collect.sv
// Bench for fft_collect: natural-order and bit-reversed instances share one stimulus stream.
module tb_fft_collect;
  typedef logic [15:0][31:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        ana_done = 1'b0;
  logic [31:0] in_data = '0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int nvalid0 = 0;

  frame_t exp0_q[$];
  frame_t exp1_q[$];
  frame_t fr0, fr1;

  fft_collect_if if0();
  fft_collect_if if1();

  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if0.ana_done = ana_done;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;
  assign if1.ana_done = ana_done;

  fft_collect #(.BIT_REV(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  fft_collect #(.BIT_REV(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  assign fr0 = {if0.fft_d15, if0.fft_d14, if0.fft_d13, if0.fft_d12, if0.fft_d11, if0.fft_d10,
                if0.fft_d9, if0.fft_d8, if0.fft_d7, if0.fft_d6, if0.fft_d5, if0.fft_d4,
                if0.fft_d3, if0.fft_d2, if0.fft_d1, if0.fft_d0};
  assign fr1 = {if1.fft_d15, if1.fft_d14, if1.fft_d13, if1.fft_d12, if1.fft_d11, if1.fft_d10,
                if1.fft_d9, if1.fft_d8, if1.fft_d7, if1.fft_d6, if1.fft_d5, if1.fft_d4,
                if1.fft_d3, if1.fft_d2, if1.fft_d1, if1.fft_d0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (if0.fft_valid === 1'b1) nvalid0 <= nvalid0 + 1;

  function automatic frame_t brev(input frame_t s);
    frame_t     r;
    logic [3:0] k4;
    for (int k = 0; k < 16; k++) begin
      k4 = 4'(k);
      r[{k4[0], k4[1], k4[2], k4[3]}] = s[k];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input frame_t s);
    exp0_q.push_back(s);
    exp1_q.push_back(brev(s));
  endtask

  task automatic stream(input frame_t s, input int n, input bit done_last,
                        output int last_cyc, output int ndrop);
    ndrop    = 0;
    last_cyc = -1;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = s[k];
      ana_done = done_last && (k == n - 1);
      #1;
      if (if0.drop === 1'b1 || if1.drop === 1'b1) ndrop++;
      last_cyc = cyc;
      tick();
    end
    in_valid = 1'b0;
    ana_done = 1'b0;
  endtask

  task automatic wait_valid(output int vc, output bit ok);
    ok = 1'b0;
    vc = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (if0.fft_valid === 1'b1) begin
        ok = 1'b1;
        vc = cyc;
      end
    end
  endtask

  task automatic pulse_done(output int c);
    ana_done = 1'b1;
    c = cyc;
    tick();
    ana_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (if0.in_ready !== 1'b1 || if1.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got=%b/%b want=1", if0.in_ready, if1.in_ready);
    end
    checks++;
    if (if0.fft_valid !== 1'b0 || if0.drop !== 1'b0) begin
      fails++; $display("FAIL reset_valid_drop got=%b/%b want=0/0", if0.fft_valid, if0.drop);
    end
    checks++;
    if (fr0 !== '0 || fr1 !== '0) begin
      fails++; $display("FAIL reset_fft_d got=%h want=0", fr0);
    end
  endtask

  task automatic test_stream();
    frame_t s, e;
    int lc, nd, vc;
    bit ok;
    for (int k = 0; k < 16; k++) s[k] = 32'(k) << 16;
    push_exp(s);
    stream(s, 16, 1'b0, lc, nd);
    checks++;
    if (nd != 0) begin fails++; $display("FAIL stream_drop got=%0d want=0", nd); end
    wait_valid(vc, ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL stream_valid_timeout got=none want=pulse");
    end else begin
      checks++;
      if (vc - lc != 2) begin fails++; $display("FAIL stream_latency got=%0d want=2", vc - lc); end
      checks++;
      if (if1.fft_valid !== 1'b1) begin fails++; $display("FAIL stream_valid1 got=%b want=1", if1.fft_valid); end
      e = exp0_q.pop_front();
      checks++;
      if (fr0 !== e) begin fails++; $display("FAIL stream_frame0 got=%h want=%h", fr0, e); end
      e = exp1_q.pop_front();
      checks++;
      if (fr1 !== e) begin fails++; $display("FAIL stream_frame1 got=%h want=%h", fr1, e); end
      checks++;
      if (if1.fft_d8 !== 32'h0001_0000 || if1.fft_d1 !== 32'h0008_0000 ||
          if1.fft_d15 !== 32'h000F_0000 || if1.fft_d6 !== 32'h0006_0000) begin
        fails++; $display("FAIL bitrev_slots got=%h/%h/%h/%h want=00010000/00080000/000f0000/00060000",
                          if1.fft_d8, if1.fft_d1, if1.fft_d15, if1.fft_d6);
      end
    end
    tick();
    checks++;
    if (if0.fft_valid !== 1'b0) begin fails++; $display("FAIL valid_one_cycle got=%b want=0", if0.fft_valid); end
    repeat (3) tick();
    checks++;
    if (nvalid0 != 1) begin fails++; $display("FAIL valid_count got=%0d want=1", nvalid0); end
    pulse_done(vc);
    tick();
  endtask

  task automatic test_backpressure();
    frame_t s, a0, a1, e;
    int lc, nd, vc;
    bit ok;
    a0 = '0; a1 = '0;
    for (int k = 0; k < 16; k++) s[k] = 32'hA000_0000 | 32'(k);
    push_exp(s);
    stream(s, 16, 1'b0, lc, nd);
    wait_valid(vc, ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL frameA_timeout got=none want=pulse");
    end else begin
      a0 = exp0_q.pop_front();
      a1 = exp1_q.pop_front();
      checks++;
      if (fr0 !== a0 || fr1 !== a1) begin fails++; $display("FAIL frameA got=%h want=%h", fr0, a0); end
    end
    tick();
    for (int k = 0; k < 16; k++) s[k] = 32'hB000_0000 | 32'(k);
    push_exp(s);
    stream(s, 16, 1'b0, lc, nd);
    checks++;
    if (nd != 0) begin fails++; $display("FAIL frameB_drop got=%0d want=0", nd); end
    checks++;
    if (if0.in_ready !== 1'b0 || if1.in_ready !== 1'b0) begin
      fails++; $display("FAIL stall_in_ready got=%b/%b want=0", if0.in_ready, if1.in_ready);
    end
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (if0.drop !== 1'b1 || if1.drop !== 1'b1) begin
      fails++; $display("FAIL drop_pulse got=%b/%b want=1", if0.drop, if1.drop);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (if0.drop !== 1'b0) begin fails++; $display("FAIL drop_clear got=%b want=0", if0.drop); end
    repeat (3) tick();
    checks++;
    if (fr0 !== a0 || fr1 !== a1) begin fails++; $display("FAIL hold_A got=%h want=%h", fr0, a0); end
    checks++;
    if (nvalid0 != 2) begin fails++; $display("FAIL stall_valid_count got=%0d want=2", nvalid0); end
  endtask

  task automatic test_release();
    frame_t s, e;
    int c, lc, nd, vc;
    bit ok;
    pulse_done(c);
    wait_valid(vc, ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL frameB_timeout got=none want=pulse");
    end else begin
      checks++;
      if (vc - c != 2) begin fails++; $display("FAIL frameB_latency got=%0d want=2", vc - c); end
      e = exp0_q.pop_front();
      checks++;
      if (fr0 !== e) begin fails++; $display("FAIL frameB0 got=%h want=%h", fr0, e); end
      e = exp1_q.pop_front();
      checks++;
      if (fr1 !== e) begin fails++; $display("FAIL frameB1 got=%h want=%h", fr1, e); end
    end
    tick();
    checks++;
    if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b want=1", if0.in_ready); end
    for (int k = 0; k < 16; k++) s[k] = 32'hC000_0000 | (32'(k) << 8) | 32'(15 - k);
    push_exp(s);
    stream(s, 16, 1'b0, lc, nd);
    checks++;
    if (nd != 0) begin fails++; $display("FAIL frameC_drop got=%0d want=0", nd); end
    pulse_done(c);
    wait_valid(vc, ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL frameC_timeout got=none want=pulse");
    end else begin
      e = exp0_q.pop_front();
      checks++;
      if (fr0 !== e) begin fails++; $display("FAIL frameC0 got=%h want=%h", fr0, e); end
      e = exp1_q.pop_front();
      checks++;
      if (fr1 !== e) begin fails++; $display("FAIL frameC1 got=%h want=%h", fr1, e); end
    end
    tick();
  endtask

  task automatic test_simultaneous();
    frame_t s, e;
    int c, lc, nd, vc;
    bit ok;
    for (int k = 0; k < 16; k++) s[k] = 32'hD000_0000 | (32'(k) * 32'h0001_0101);
    push_exp(s);
    stream(s, 16, 1'b1, lc, nd);
    checks++;
    if (nd != 0) begin fails++; $display("FAIL simul_drop got=%0d want=0", nd); end
    wait_valid(vc, ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL frameD_timeout got=none want=pulse");
    end else begin
      checks++;
      if (vc - lc != 2) begin fails++; $display("FAIL frameD_latency got=%0d want=2", vc - lc); end
      e = exp0_q.pop_front();
      checks++;
      if (fr0 !== e) begin fails++; $display("FAIL frameD0 got=%h want=%h", fr0, e); end
      e = exp1_q.pop_front();
      checks++;
      if (fr1 !== e) begin fails++; $display("FAIL frameD1 got=%h want=%h", fr1, e); end
    end
    tick();
    checks++;
    if (if0.in_ready !== 1'b1) begin fails++; $display("FAIL simul_in_ready got=%b want=1", if0.in_ready); end
    pulse_done(c);
    tick();
  endtask

  task automatic test_reset_midframe();
    frame_t s, e;
    int lc, nd, vc;
    bit ok;
    for (int k = 0; k < 16; k++) s[k] = 32'hFFFF_FFFF;
    stream(s, 7, 1'b0, lc, nd);
    rst = 1'b1;
    #2;
    checks++;
    if (fr0 !== '0 || fr1 !== '0 || if0.in_ready !== 1'b1 || if0.fft_valid !== 1'b0) begin
      fails++; $display("FAIL async_reset got=%h rdy=%b vld=%b want=0 rdy=1 vld=0",
                        fr0, if0.in_ready, if0.fft_valid);
    end
    #2;
    rst = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) s[k] = 32'h0001_0001;
    push_exp(s);
    stream(s, 16, 1'b0, lc, nd);
    wait_valid(vc, ok);
    checks++;
    if (!ok) begin
      fails++; $display("FAIL post_reset_timeout got=none want=pulse");
    end else begin
      checks++;
      if (vc - lc != 2) begin fails++; $display("FAIL post_reset_latency got=%0d want=2", vc - lc); end
      e = exp0_q.pop_front();
      checks++;
      if (fr0 !== e) begin fails++; $display("FAIL post_reset_frame0 got=%h want=%h", fr0, e); end
      e = exp1_q.pop_front();
      checks++;
      if (fr1 !== e) begin fails++; $display("FAIL post_reset_frame1 got=%h want=%h", fr1, e); end
    end
    tick();
    pulse_done(vc);
    tick();
    checks++;
    if (exp0_q.size() != 0) begin fails++; $display("FAIL leftover_frames got=%0d want=0", exp0_q.size()); end
  endtask

  initial begin
    #22;
    rst = 1'b0;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_release();
    test_simultaneous();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
